multicycle_ctrl: RTL and testbench

// - Multicycle MIPS controller FSM; sequences shared datapath (single ALU, unified memory, IR, PC, regfile).
// - Decodes opcode in DECODE and drives a Moore control word per state.
//   * Memory-access states are qualified by a mem_ready handshake.
// - Sits beside the datapath; replaces the single-cycle opcode control ROM when running the multicycle core.
// - Keeps a retired-instruction counter for the bench and for perf reads.

---
 rtl/mc_ctrl_pkg.sv | 56 +++++
 rtl/mc_ctrl_outdec.sv | 61 ++++++
 rtl/multicycle_ctrl.sv | 121 ++++++++++++
 tb/tb_multicycle_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS controller: state codes, opcodes,
// datapath mux encodings and the decoded control word layout.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RTWB   = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // irwrite is absent: it depends only on the FETCH handshake, handled in the top.
    typedef struct packed {
        logic       pcwrite;
        logic       pcwritecond;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       regdst;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsource;
    } ctrl_word_t;

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Moore output decoder: maps the controller state to its 15-bit control word.
// Unused state codes decode to an all-zero word.
module mc_ctrl_outdec
    import mc_ctrl_pkg::*;
(
    input  state_e     state_i,
    output ctrl_word_t ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.memread = 1'b1;
                ctrl_o.alusrcb = SRCB_FOUR;
            end
            S_DECODE: ctrl_o.alusrcb = SRCB_IMMSH;
            S_MEMADR: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.alusrcb = SRCB_IMM;
            end
            S_MEMRD: begin
                ctrl_o.memread = 1'b1;
                ctrl_o.iord    = 1'b1;
            end
            S_MEMWB: begin
                ctrl_o.memtoreg = 1'b1;
                ctrl_o.regwrite = 1'b1;
            end
            S_MEMWR: begin
                ctrl_o.memwrite = 1'b1;
                ctrl_o.iord     = 1'b1;
            end
            S_EXEC: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.aluop   = ALUOP_FUNCT;
            end
            S_RTWB: begin
                ctrl_o.regdst   = 1'b1;
                ctrl_o.regwrite = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alusrca     = 1'b1;
                ctrl_o.aluop       = ALUOP_SUB;
                ctrl_o.pcwritecond = 1'b1;
                ctrl_o.pcsource    = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl_o.pcwrite  = 1'b1;
                ctrl_o.pcsource = PCSRC_JUMP;
            end
            S_ADDIEX: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.alusrcb = SRCB_IMM;
            end
            S_ADDIWB: ctrl_o.regwrite = 1'b1;
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS controller: state register, opcode-driven sequencing, memory
// handshake qualification, reset gating of the control word and a retire counter.
module multicycle_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             pcwrite,
    output logic             pcwritecond,
    output logic             iord,
    output logic             memread,
    output logic             memwrite,
    output logic             irwrite,
    output logic             memtoreg,
    output logic             regdst,
    output logic             regwrite,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic [1:0]       aluop,
    output logic [1:0]       pcsource,
    output logic [3:0]       state,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count
);

    // Handshake: a request (memread/memwrite) is held steady in FETCH, MEMRD and
    // MEMWR until mem_ready=1 in the same cycle completes it; the state advances
    // on that edge. mem_ready has no effect in any other state.
    state_e           state_q, state_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             retire;
    ctrl_word_t       cw, cw_g;
    logic             fetch_done;

    always_comb begin
        state_d   = state_q;
        illegal_d = 1'b0;
        retire    = 1'b0;
        case (state_q)
            S_FETCH: if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDIEX;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_MEMWR: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_EXEC:   state_d = S_RTWB;
            S_ADDIEX: state_d = S_ADDIWB;
            S_RTWB, S_BRANCH, S_JUMP, S_ADDIWB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    assign cnt_d = retire ? cnt_q + {{(CNT_W-1){1'b0}}, 1'b1} : cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

    mc_ctrl_outdec u_outdec (
        .state_i (state_q),
        .ctrl_o  (cw)
    );

    // Outputs are gated by rst_n so an asserted reset kills any write at once.
    assign cw_g       = rst_n ? cw : '0;
    assign fetch_done = rst_n && (state_q == S_FETCH) && mem_ready;

    assign pcwrite     = cw_g.pcwrite | fetch_done;
    assign irwrite     = fetch_done;
    assign pcwritecond = cw_g.pcwritecond;
    assign iord        = cw_g.iord;
    assign memread     = cw_g.memread;
    assign memwrite    = cw_g.memwrite;
    assign memtoreg    = cw_g.memtoreg;
    assign regdst      = cw_g.regdst;
    assign regwrite    = cw_g.regwrite;
    assign alusrca     = cw_g.alusrca;
    assign alusrcb     = cw_g.alusrcb;
    assign aluop       = cw_g.aluop;
    assign pcsource    = cw_g.pcsource;
    assign state       = state_q;
    assign illegal_op  = illegal_q & rst_n;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: instruction-level reference model, table of
// per-opcode latencies, directed corner sequences and randomized traffic.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;

    logic a_pcwrite, a_pcwritecond, a_iord, a_memread, a_memwrite, a_irwrite;
    logic a_memtoreg, a_regdst, a_regwrite, a_alusrca, a_illegal;
    logic [1:0] a_alusrcb, a_aluop, a_pcsource;
    logic [3:0] a_state;
    logic [31:0] a_count;

    logic b_pcwrite, b_pcwritecond, b_iord, b_memread, b_memwrite, b_irwrite;
    logic b_memtoreg, b_regdst, b_regwrite, b_alusrca, b_illegal;
    logic [1:0] b_alusrcb, b_aluop, b_pcsource;
    logic [3:0] b_state;
    logic [3:0] b_count;

    logic [20:0] a_vec, b_vec;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pcwrite(a_pcwrite), .pcwritecond(a_pcwritecond), .iord(a_iord),
        .memread(a_memread), .memwrite(a_memwrite), .irwrite(a_irwrite),
        .memtoreg(a_memtoreg), .regdst(a_regdst), .regwrite(a_regwrite),
        .alusrca(a_alusrca), .alusrcb(a_alusrcb), .aluop(a_aluop),
        .pcsource(a_pcsource), .state(a_state), .illegal_op(a_illegal),
        .instr_count(a_count)
    );

    multicycle_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pcwrite(b_pcwrite), .pcwritecond(b_pcwritecond), .iord(b_iord),
        .memread(b_memread), .memwrite(b_memwrite), .irwrite(b_irwrite),
        .memtoreg(b_memtoreg), .regdst(b_regdst), .regwrite(b_regwrite),
        .alusrca(b_alusrca), .alusrcb(b_alusrcb), .aluop(b_aluop),
        .pcsource(b_pcsource), .state(b_state), .illegal_op(b_illegal),
        .instr_count(b_count)
    );

    assign a_vec = {a_pcwrite, a_pcwritecond, a_iord, a_memread, a_memwrite, a_irwrite,
                    a_memtoreg, a_regdst, a_regwrite, a_alusrca, a_alusrcb, a_aluop,
                    a_pcsource, a_state, a_illegal};
    assign b_vec = {b_pcwrite, b_pcwritecond, b_iord, b_memread, b_memwrite, b_irwrite,
                    b_memtoreg, b_regdst, b_regwrite, b_alusrca, b_alusrcb, b_aluop,
                    b_pcsource, b_state, b_illegal};

    // ---------------- reference model ----------------
    // An instruction is the list of states it visits; FETCH, MEMRD and MEMWR wait on mem_ready.
    int          plan_q[$];
    bit          plan_legal;
    int          pos;
    logic        exp_ill;
    int unsigned exp_cnt;

    function automatic void load_plan(input logic [5:0] op);
        plan_legal = 1'b1;
        case (op)
            6'b000000: plan_q = '{0, 1, 6, 7};
            6'b100011: plan_q = '{0, 1, 2, 3, 4};
            6'b101011: plan_q = '{0, 1, 2, 5};
            6'b000100: plan_q = '{0, 1, 8};
            6'b000010: plan_q = '{0, 1, 9};
            6'b001000: plan_q = '{0, 1, 10, 11};
            default: begin
                plan_q     = '{0, 1};
                plan_legal = 1'b0;
            end
        endcase
    endfunction

    // Control outputs as a predicate of the visited state, read straight off the state table.
    function automatic logic [20:0] exp_vec(input int st, input logic mr, input logic ill);
        logic pcw, pcwc, iord_e, mrd, mwr, irw, m2r, rdst, rw, srca;
        logic [1:0] srcb, aop, psrc;
        logic [3:0] st4;
        pcw  = (st == 0 && mr) || st == 9;
        pcwc = (st == 8);
        iord_e = (st == 3 || st == 5);
        mrd  = (st == 0 || st == 3);
        mwr  = (st == 5);
        irw  = (st == 0 && mr);
        m2r  = (st == 4);
        rdst = (st == 7);
        rw   = (st == 4 || st == 7 || st == 11);
        srca = (st == 2 || st == 6 || st == 8 || st == 10);
        srcb = (st == 0) ? 2'd1 : (st == 1) ? 2'd3 : (st == 2 || st == 10) ? 2'd2 : 2'd0;
        aop  = (st == 6) ? 2'd2 : (st == 8) ? 2'd1 : 2'd0;
        psrc = (st == 8) ? 2'd1 : (st == 9) ? 2'd2 : 2'd0;
        st4  = 4'(st);
        return {pcw, pcwc, iord_e, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, aop, psrc, st4, ill};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic reset_model();
        pos     = 0;
        exp_ill = 1'b0;
        exp_cnt = 0;
        load_plan(opcode);
    endtask

    task automatic start_instr(input logic [5:0] op);
        opcode = op;
        load_plan(op);
    endtask

    // Drive mem_ready, then compare both instances against the model at the falling edge.
    task automatic cyc_begin(input logic mr);
        logic [20:0] e;
        logic [31:0] e_cnt4;
        mem_ready = mr;
        @(negedge clk);
        e = exp_vec(plan_q[pos], mem_ready, exp_ill);
        e_cnt4 = {28'd0, exp_cnt[3:0]};
        chk("ctrl_word", {11'd0, a_vec}, {11'd0, e});
        chk("ctrl_word_w4", {11'd0, b_vec}, {11'd0, e});
        chk("instr_count", a_count, exp_cnt);
        chk("instr_count_w4", {28'd0, b_count}, e_cnt4);
    endtask

    task automatic cyc_end();
        int  cur;
        bit  adv;
        @(posedge clk);
        cur = plan_q[pos];
        adv = !(cur == 0 || cur == 3 || cur == 5) || mem_ready;
        exp_ill = 1'b0;
        if (adv) begin
            if (pos == plan_q.size() - 1) begin
                if (plan_legal) exp_cnt++;
                else exp_ill = 1'b1;
                pos = 0;
            end else begin
                pos++;
            end
        end
        #1;
    endtask

    typedef struct {
        logic [5:0] op;
        int         cycles;
        int         delta;
    } tv_t;

    tv_t tv[8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int lw_st[5];
        logic sw_mr[7];
        logic [31:0] c0;
        logic [5:0] ops[6];

        tv[0] = '{6'b000000, 4, 1};
        tv[1] = '{6'b100011, 5, 1};
        tv[2] = '{6'b101011, 4, 1};
        tv[3] = '{6'b000100, 3, 1};
        tv[4] = '{6'b000010, 3, 1};
        tv[5] = '{6'b001000, 4, 1};
        tv[6] = '{6'b111111, 2, 0};
        tv[7] = '{6'b000001, 2, 0};
        lw_st = '{0, 1, 2, 3, 4};
        sw_mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        ops   = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};

        // Reset: everything zero even with mem_ready high in FETCH.
        rst_n = 1'b0; opcode = 6'd0; mem_ready = 1'b1;
        reset_model();
        #2;
        chk("reset_outputs", {11'd0, a_vec}, 32'd0);
        chk("reset_outputs_w4", {11'd0, b_vec}, 32'd0);
        chk("reset_count", a_count, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Per-opcode latency and retire count with memory always ready.
        for (int i = 0; i < 8; i++) begin
            c0 = a_count;
            start_instr(tv[i].op);
            n = 0;
            do begin
                cyc_begin(1'b1);
                cyc_end();
                n++;
            end while (a_state != 4'd0 && n < 20);
            chk("tv_cycles", 32'(n), 32'(tv[i].cycles));
            chk("tv_retired", a_count - c0, 32'(tv[i].delta));
        end

        // lw state trace; writeback strobes only in the last cycle.
        c0 = a_count;
        start_instr(6'b100011);
        for (int i = 0; i < 5; i++) begin
            cyc_begin(1'b1);
            chk("lw_state", {28'd0, a_state}, 32'(lw_st[i]));
            chk("lw_regwrite", {31'd0, a_regwrite}, {31'd0, i == 4});
            chk("lw_memtoreg", {31'd0, a_memtoreg}, {31'd0, i == 4});
            cyc_end();
        end
        chk("lw_end_state", {28'd0, a_state}, 32'd0);
        chk("lw_retired", a_count - c0, 32'd1);

        // sw with three wait cycles in MEMWR.
        c0 = a_count;
        start_instr(6'b101011);
        for (int i = 0; i < 7; i++) begin
            cyc_begin(sw_mr[i]);
            if (i >= 3) begin
                chk("sw_memwrite_held", {31'd0, a_memwrite}, 32'd1);
                chk("sw_iord_held", {31'd0, a_iord}, 32'd1);
            end
            cyc_end();
        end
        chk("sw_end_state", {28'd0, a_state}, 32'd0);
        chk("sw_retired", a_count - c0, 32'd1);

        // beq
        start_instr(6'b000100);
        for (int i = 0; i < 3; i++) begin
            cyc_begin(1'b1);
            if (i == 2) begin
                chk("beq_state", {28'd0, a_state}, 32'd8);
                chk("beq_pcwritecond", {31'd0, a_pcwritecond}, 32'd1);
                chk("beq_pcsource", {30'd0, a_pcsource}, 32'd1);
                chk("beq_aluop", {30'd0, a_aluop}, 32'd1);
            end
            cyc_end();
        end
        chk("beq_end_state", {28'd0, a_state}, 32'd0);

        // Illegal opcode: one-cycle pulse after DECODE, nothing retired.
        c0 = a_count;
        start_instr(6'b111111);
        cyc_begin(1'b1); cyc_end();
        cyc_begin(1'b1); cyc_end();
        cyc_begin(1'b0);
        chk("illegal_pulse", {31'd0, a_illegal}, 32'd1);
        chk("illegal_state", {28'd0, a_state}, 32'd0);
        chk("illegal_count", a_count, c0);
        cyc_end();
        cyc_begin(1'b0);
        chk("illegal_clear", {31'd0, a_illegal}, 32'd0);
        cyc_end();

        // Asynchronous reset while MEMWR waits.
        start_instr(6'b101011);
        for (int i = 0; i < 3; i++) begin
            cyc_begin(1'b1); cyc_end();
        end
        cyc_begin(1'b0);
        chk("memwr_before_reset", {31'd0, a_memwrite}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("reset_async_memwrite", {31'd0, a_memwrite}, 32'd0);
        chk("reset_async_iord", {31'd0, a_iord}, 32'd0);
        chk("reset_async_state", {28'd0, a_state}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        reset_model();
        chk("post_reset_state", {28'd0, a_state}, 32'd0);
        chk("post_reset_count", a_count, 32'd0);
        chk("post_reset_count_w4", {28'd0, b_count}, 32'd0);

        // 16 jumps: the 4-bit counter wraps 15 -> 0.
        for (int k = 0; k < 16; k++) begin
            start_instr(6'b000010);
            for (int i = 0; i < 3; i++) begin
                cyc_begin(1'b1);
                if (k == 15 && i == 0) chk("wrap_pre", {28'd0, b_count}, 32'd15);
                if (i == 2) begin
                    chk("jump_pcwrite", {31'd0, a_pcwrite}, 32'd1);
                    chk("jump_pcsource", {30'd0, a_pcsource}, 32'd2);
                end
                cyc_end();
            end
        end
        chk("wrap_w4", {28'd0, b_count}, 32'd0);
        chk("wrap_w32", a_count, 32'd16);

        // Randomized instruction mix with random memory stalls.
        for (int k = 0; k < 300; k++) begin
            int r;
            r = $urandom_range(0, 7);
            if (r < 6) start_instr(ops[r]);
            else if (r == 6) start_instr(6'($urandom_range(0, 63)));
            else start_instr(6'b111111);
            n = 0;
            do begin
                cyc_begin($urandom_range(0, 3) != 0);
                cyc_end();
                n++;
            end while (pos != 0 && n < 60);
            if (n >= 60) chk("random_progress", 32'(n), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
